// File: rtl/reg_bank_bus.sv
// Register bank with bus write/read, per-register increment and registered tri-state read port.
// Optional shadow bank (SNAP/RESTORE) is built only when REG_BANK_SNAPSHOT_EN is defined.
module reg_bank_bus #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             WR,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] BIN,
  input  logic             INC,
  input  logic [AW-1:0]    IADDR,
  input  logic             LDBUS,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] BOUT,
  output logic             BVALID,
  output logic             ZERO,
  input  logic             SNAP,
  input  logic             RESTORE
);

  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] regs      [DEPTH];
  logic [WIDTH-1:0] regs_next [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] bout_q;
  logic             bvalid_q;
  logic             zero_q;
  logic             wr_ok;
  logic             inc_ok;
  logic             restore_act;

  assign wr_ok  = WR  && ({1'b0, WADDR} < DEPTH_LIM);
  assign inc_ok = INC && ({1'b0, IADDR} < DEPTH_LIM);

`ifdef REG_BANK_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow [DEPTH];

  assign restore_act = RESTORE;

  // Shadow captures the values the bank holds after this edge; RESTORE wins over SNAP.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (SNAP && !RESTORE) begin
      shadow <= regs_next;
    end
  end
`else
  logic unused_snapshot;

  assign restore_act     = 1'b0;
  assign unused_snapshot = SNAP ^ RESTORE;
`endif

  // Per-register next value: RESTORE > WR > INC (WR to the same index drops the INC).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_next[i] = regs[i];
`ifdef REG_BANK_SNAPSHOT_EN
      if (restore_act) begin
        regs_next[i] = shadow[i];
      end else
`endif
      if (wr_ok && (WADDR == AW'(i))) begin
        regs_next[i] = BIN;
      end else if (inc_ok && (IADDR == AW'(i))) begin
        regs_next[i] = regs[i] + WIDTH'(1);
      end
    end
  end

  // Read mux sees pre-edge contents; unmatched (out-of-range) addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RADDR == AW'(i)) rd_data = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      bout_q   <= '0;
      bvalid_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      regs     <= regs_next;
      bvalid_q <= LDBUS;
      if (LDBUS) begin
        bout_q <= rd_data;
        zero_q <= (rd_data == '0);
      end
    end
  end

  assign BOUT   = bvalid_q ? bout_q : {WIDTH{1'bz}};
  assign BVALID = bvalid_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_reg_bank_bus.sv
// Directed scoreboard bench for reg_bank_bus; expected bus results are queued at drive time
// and popped one edge later. Define REG_BANK_SNAPSHOT_EN to exercise the shadow bank.
module tb_reg_bank_bus;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 4;
`ifdef REG_BANK_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             RST = 1'b0;
  logic             WR = 1'b0;
  logic [AW-1:0]    WADDR = '0;
  logic [WIDTH-1:0] BIN = '0;
  logic             INC = 1'b0;
  logic [AW-1:0]    IADDR = '0;
  logic             LDBUS = 1'b0;
  logic [AW-1:0]    RADDR = '0;
  logic [WIDTH-1:0] BOUT;
  logic             BVALID;
  logic             ZERO;
  logic             SNAP = 1'b0;
  logic             RESTORE = 1'b0;

  exp_t             expQ [$];
  logic [WIDTH-1:0] model  [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic             expZero = 1'b1;
  int               total = 0;
  int               bad = 0;

  reg_bank_bus #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .RST(RST), .WR(WR), .WADDR(WADDR), .BIN(BIN),
    .INC(INC), .IADDR(IADDR), .LDBUS(LDBUS), .RADDR(RADDR),
    .BOUT(BOUT), .BVALID(BVALID), .ZERO(ZERO),
    .SNAP(SNAP), .RESTORE(RESTORE)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    exp_t e;
    total++;
    assert (expQ.size() > 0) else begin
      bad++;
      $error("[TB] FAIL %s scoreboard empty got=0 want=1", tag);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      assert (BVALID === e.valid) else begin
        bad++;
        $error("[TB] FAIL %s bvalid got=%0b want=%0b", tag, BVALID, e.valid);
      end
      if (e.valid) begin
        total++;
        assert (BOUT === e.data) else begin
          bad++;
          $error("[TB] FAIL %s bout got=%h want=%h", tag, BOUT, e.data);
        end
      end
      total++;
      assert (ZERO === e.zero) else begin
        bad++;
        $error("[TB] FAIL %s zero got=%0b want=%0b", tag, ZERO, e.zero);
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst,
                               input logic wr, input logic [AW-1:0] waddr, input logic [WIDTH-1:0] bin,
                               input logic inc, input logic [AW-1:0] iaddr,
                               input logic ld, input logic [AW-1:0] raddr,
                               input logic snap, input logic restore);
    exp_t             e;
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [WIDTH-1:0] rd;
    RST = rst; WR = wr; WADDR = waddr; BIN = bin; INC = inc; IADDR = iaddr;
    LDBUS = ld; RADDR = raddr; SNAP = snap; RESTORE = restore;
    e = '0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        model[i]  = '0;
        shadow[i] = '0;
      end
      expZero = 1'b1;
    end else begin
      rd = (int'(raddr) < DEPTH) ? model[int'(raddr)] : '0;
      e.valid = ld;
      if (ld) begin
        e.data  = rd;
        expZero = (rd == '0);
      end
      nxt = model;
      if (SNAP_EN && restore) begin
        nxt = shadow;
      end else begin
        if (wr && int'(waddr) < DEPTH) nxt[int'(waddr)] = bin;
        if (inc && int'(iaddr) < DEPTH && !(wr && waddr == iaddr))
          nxt[int'(iaddr)] = model[int'(iaddr)] + 16'd1;
      end
      if (SNAP_EN && snap && !restore) shadow = nxt;
      model = nxt;
    end
    e.zero = expZero;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    applyStimulus("write", 1'b0, 1'b1, a, d, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic doRead(input string tag, input logic [AW-1:0] a);
    applyStimulus(tag, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic doIdle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    applyStimulus("reset", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    doIdle("idle_after_reset");

    doWrite(4'd3, 16'h1234);
    doRead("read_r3", 4'd3);
    doIdle("release_bus");

    doWrite(4'd2, 16'hFFFF);
    applyStimulus("inc_wrap", 1'b0, 1'b0, '0, '0, 1'b1, 4'd2, 1'b0, '0, 1'b0, 1'b0);
    doRead("read_wrap_r2", 4'd2);

    applyStimulus("wr_inc_same", 1'b0, 1'b1, 4'd5, 16'h00AA, 1'b1, 4'd5, 1'b0, '0, 1'b0, 1'b0);
    doRead("read_r5", 4'd5);
    doIdle("zero_holds_low");
    doWrite(4'd4, 16'd9);
    applyStimulus("wr_inc_diff", 1'b0, 1'b1, 4'd1, 16'd7, 1'b1, 4'd4, 1'b0, '0, 1'b0, 1'b0);
    doRead("read_r1", 4'd1);
    doRead("read_r4", 4'd4);

    doWrite(4'd0, 16'h0001);
    applyStimulus("rbw_r0", 1'b0, 1'b1, 4'd0, 16'h5555, 1'b0, '0, 1'b1, 4'd0, 1'b0, 1'b0);
    doRead("read_r0_new", 4'd0);

    applyStimulus("oob_write", 1'b0, 1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd12, 1'b0, '0, 1'b0, 1'b0);
    doRead("oob_read", 4'd12);
    doRead("alias_r1", 4'd1);

    doWrite(4'd6, 16'h0042);
    applyStimulus("snap", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    doWrite(4'd6, 16'h0099);
    applyStimulus("restore", 1'b0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd3, 1'b0, '0, 1'b0, 1'b1);
    doRead("read_r6", 4'd6);
    doWrite(4'd6, 16'h0011);
    applyStimulus("snap_and_restore", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus("snap_post_update", 1'b0, 1'b1, 4'd2, 16'h0C0C, 1'b1, 4'd5, 1'b0, '0, 1'b1, 1'b0);
    doWrite(4'd2, 16'h0000);
    applyStimulus("restore2", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < DEPTH; i++) doRead($sformatf("sweep_r%0d", i), AW'(i));

    applyStimulus("reset_override", 1'b1, 1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd4, 1'b1, 4'd3, 1'b0, 1'b0);
    doIdle("after_reset_override");
    for (int i = 0; i < DEPTH; i++) doRead($sformatf("cleared_r%0d", i), AW'(i));
    doIdle("final_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_bus.md
REG_BANK_BUS -- requirements
Module: reg_bank_bus

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, data width of each register in bits.
REQ-002 The module SHALL have parameter DEPTH, default 8, number of registers (2..64).
REQ-003 The module SHALL have parameter AW, default 3, address width; the integrator SHALL set AW >= ceil(log2(DEPTH)).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 WR  input  1  write strobe; loads BIN into register WADDR.
REQ-007 WADDR  input  AW  write register index.
REQ-008 BIN  input  WIDTH  data from the bus.
REQ-009 INC  input  1  increment strobe for register IADDR.
REQ-010 IADDR  input  AW  increment register index.
REQ-011 LDBUS  input  1  request to drive register RADDR onto the bus.
REQ-012 RADDR  input  AW  read register index.
REQ-013 BOUT  output  WIDTH  bus output; tri-stated (all Z) when not driving.
REQ-014 BVALID  output  1  high while BOUT is driven.
REQ-015 ZERO  output  1  high when the register last driven onto BOUT was zero.
REQ-016 SNAP  input  1  snapshot all registers into the shadow bank.
REQ-017 RESTORE  input  1  copy the shadow bank back into the registers.

Function
REQ-018 Each write and increment SHALL take effect at the rising edge of the cycle in which its strobe is sampled high.
REQ-019 Register update priority per register SHALL be: RST > RESTORE > WR > INC.
REQ-020 WR and INC to the same address in the same cycle SHALL apply WR only; the increment is dropped.
REQ-021 WR and INC to different addresses in the same cycle SHALL both take effect.
REQ-022 INC SHALL add 1 modulo 2^WIDTH; all-ones SHALL wrap to 0 with no flag.
REQ-023 Writes or increments with an address >= DEPTH SHALL be ignored.
REQ-024 Bus read SHALL be registered: LDBUS sampled high at edge N SHALL drive BOUT and assert BVALID from edge N until edge N+1.
REQ-025 The value driven SHALL be the register content before any same-cycle write (read-before-write).
REQ-026 LDBUS sampled low SHALL set BOUT to all Z and deassert BVALID at that edge.
REQ-027 A read with RADDR >= DEPTH SHALL drive all zeros with BVALID high.
REQ-028 ZERO SHALL update only on edges where LDBUS is sampled high; it holds its value otherwise.

Reset
REQ-029 RST sampled high SHALL clear every register to 0, clear the shadow bank to 0, set BOUT to Z, and set BVALID to 0 and ZERO to 1.
REQ-030 RST SHALL override every strobe sampled in the same cycle, including in-flight reads, which are aborted.

Configuration
REQ-031 With macro REG_BANK_SNAPSHOT_EN defined, a shadow bank of DEPTH x WIDTH SHALL exist.
REQ-032 With REG_BANK_SNAPSHOT_EN defined, SNAP SHALL copy the post-update register values of that edge into the shadow bank.
REQ-033 With REG_BANK_SNAPSHOT_EN defined, RESTORE SHALL load all registers from the shadow bank, overriding WR and INC.
REQ-034 With REG_BANK_SNAPSHOT_EN defined, SNAP and RESTORE high together SHALL perform RESTORE only.
REQ-035 Without REG_BANK_SNAPSHOT_EN, SNAP and RESTORE SHALL be ignored and no shadow storage SHALL be synthesised.

Verification
REQ-036 Reset, then write 0x1234 to reg 3, then LDBUS RADDR=3 -> BOUT=0x1234 with BVALID=1 one edge later, then Z and BVALID=0 when LDBUS drops.
REQ-037 Write 0xFFFF to reg 2, then INC reg 2 -> reg 2 reads 0x0000 and ZERO=1.
REQ-038 Same cycle WR reg 5=0x00AA and INC reg 5 -> reg 5 reads 0x00AA; same cycle WR reg 1=7 and INC reg 4 (previously 9) -> reg 1=7, reg 4=10.
REQ-039 Same cycle WR reg 0=0x5555 and LDBUS RADDR=0 (old 0x0001) -> BOUT=0x0001; the next read gives 0x5555.
REQ-040 With REG_BANK_SNAPSHOT_EN defined: write reg 6=0x0042, SNAP, write reg 6=0x0099, RESTORE -> reg 6 reads 0x0042; without the macro the same sequence -> reg 6 reads 0x0099.
REQ-041 Assert RST in the same cycle as WR, INC and LDBUS -> all registers read 0, BOUT=Z, BVALID=0, ZERO=1.
